// File: rtl/instr_decode_issue.sv
`default_nettype none
// ============================================================================
// Module      : instr_decode_issue
// Description : Decode/issue stage with a register scoreboard that stalls
//               issue on RAW/WAW hazards against in-flight writes.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_decode_issue #(
    parameter logic [3:0] ZERO_REG = 4'd0,
    parameter int         CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [31:0]      in_instr,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       op,
    output logic             form,
    output logic [1:0]       vec,
    output logic [3:0]       A,
    output logic [3:0]       B,
    output logic [3:0]       C,
    output logic [3:0]       D,
    output logic [3:0]       Y1,
    output logic [3:0]       Y2,
    output logic [1:0]       write,
    output logic [3:0]       zero_reg,
    input  logic             wb_valid,
    input  logic [15:0]      wb_mask,
    output logic [15:0]      sb_pending,
    output logic             err,
    output logic [CNT_W-1:0] issue_count,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [2:0]       w_op;
    logic             w_form;
    logic [1:0]       w_vec;
    logic [1:0]       w_write;
    logic [3:0]       w_y1, w_y2, w_a, w_b, w_c, w_d;
    logic [15:0]      w_clr;
    logic [15:0]      w_eff;
    logic [15:0]      w_set;
    logic [15:0]      w_sb_next;
    logic             w_hazard;
    logic             w_illegal;
    logic             w_slot_free;
    logic             w_accept;
    logic             w_issue;

    logic             r_out_valid;
    logic [2:0]       r_op;
    logic             r_form;
    logic [1:0]       r_vec;
    logic [1:0]       r_write;
    logic [3:0]       r_y1, r_y2, r_a, r_b, r_c, r_d;
    logic [15:0]      r_sb;
    logic             r_err;
    logic [CNT_W-1:0] r_issue_count;
    logic [CNT_W-1:0] r_stall_count;

    function automatic logic f_busy(input logic [3:0] idx, input logic [15:0] eff);
        return (idx != ZERO_REG) && eff[idx];
    endfunction

    assign w_op    = in_instr[31:29];
    assign w_form  = in_instr[28];
    assign w_vec   = in_instr[27:26];
    assign w_write = in_instr[25:24];
    assign w_y1    = in_instr[23:20];
    assign w_y2    = in_instr[19:16];
    assign w_a     = in_instr[15:12];
    assign w_b     = in_instr[11:8];
    assign w_c     = in_instr[7:4];
    assign w_d     = in_instr[3:0];

    // Retiring writes bypass into this cycle's hazard check.
    assign w_clr = wb_valid ? wb_mask : 16'h0000;
    assign w_eff = r_sb & ~w_clr;

    assign w_hazard = f_busy(w_a, w_eff) || f_busy(w_b, w_eff) ||
                      f_busy(w_c, w_eff) || f_busy(w_d, w_eff) ||
                      (w_write[0] && f_busy(w_y1, w_eff)) ||
                      (w_write[1] && f_busy(w_y2, w_eff));

    assign w_illegal   = (w_write == 2'b11) && (w_y1 == w_y2);
    assign w_slot_free = !r_out_valid || out_ready;
    assign in_ready    = w_slot_free && !w_hazard;
    assign w_accept    = in_valid && in_ready;
    assign w_issue     = w_accept && !w_illegal;

    always_comb begin
        w_set = 16'h0000;
        if (w_issue) begin
            if (w_write[0] && (w_y1 != ZERO_REG)) w_set[w_y1] = 1'b1;
            if (w_write[1] && (w_y2 != ZERO_REG)) w_set[w_y2] = 1'b1;
        end
        // Set is applied after clear so a same-cycle re-issue keeps its bit.
        w_sb_next           = (r_sb & ~w_clr) | w_set;
        w_sb_next[ZERO_REG] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid   <= 1'b0;
            r_op          <= 3'd0;
            r_form        <= 1'b0;
            r_vec         <= 2'd0;
            r_write       <= 2'd0;
            r_y1          <= 4'd0;
            r_y2          <= 4'd0;
            r_a           <= 4'd0;
            r_b           <= 4'd0;
            r_c           <= 4'd0;
            r_d           <= 4'd0;
            r_sb          <= 16'h0000;
            r_err         <= 1'b0;
            r_issue_count <= '0;
            r_stall_count <= '0;
        end else begin
            r_sb <= w_sb_next;

            if (w_issue) begin
                r_out_valid <= 1'b1;
                r_op        <= w_op;
                r_form      <= w_form;
                r_vec       <= w_vec;
                r_write     <= w_write;
                r_y1        <= w_y1;
                r_y2        <= w_y2;
                r_a         <= w_a;
                r_b         <= w_b;
                r_c         <= w_c;
                r_d         <= w_d;
                if (r_issue_count != c_cnt_max) r_issue_count <= r_issue_count + c_cnt_one;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end

            if (w_accept && w_illegal) r_err <= 1'b1;

            // Only hazard stalls count; a blocked output slot is not a stall here.
            if (in_valid && w_slot_free && w_hazard && (r_stall_count != c_cnt_max))
                r_stall_count <= r_stall_count + c_cnt_one;
        end
    end

    assign out_valid   = r_out_valid;
    assign op          = r_op;
    assign form        = r_form;
    assign vec         = r_vec;
    assign write       = r_write;
    assign Y1          = r_y1;
    assign Y2          = r_y2;
    assign A           = r_a;
    assign B           = r_b;
    assign C           = r_c;
    assign D           = r_d;
    assign zero_reg    = ZERO_REG;
    assign sb_pending  = r_sb;
    assign err         = r_err;
    assign issue_count = r_issue_count;
    assign stall_count = r_stall_count;

endmodule
`default_nettype wire

// File: doc/instr_decode_issue.md
Name: instr_decode_issue

Overview:
- Decode/issue stage directly upstream of the datapath.
- Accepts 32-bit instruction words from fetch over a valid/ready handshake and decodes them into the datapath control fields (op, form, vec, A–D, Y1, Y2, write, zero_reg).
- Holds decoded fields in an output register and presents them with a valid/ready handshake.
- A 16-bit scoreboard stalls issue on RAW/WAW hazards against in-flight register writes.

Parameters:
- ZERO_REG, 4'd0, index of the hardwired-zero register; never marked pending and never causes a hazard.
- CNT_W, 16, width of the saturating issue and stall counters.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  fetch offers instruction
- in_instr  in  32  instruction word
- in_ready  out  1  stage can accept this cycle
- out_valid  out  1  decoded fields valid
- out_ready  in  1  datapath consumes fields this cycle
- op  out  3  ALU op
- form  out  1  ALU form
- vec  out  2  vector mode
- A, B, C, D  out  4 each  source register indices
- Y1, Y2  out  4 each  destination indices
- write  out  2  bit0 = write Y1, bit1 = write Y2
- zero_reg  out  4  constant ZERO_REG
- wb_valid  in  1  writeback completing
- wb_mask  in  16  registers whose pending write retires
- sb_pending  out  16  scoreboard state
- err  out  1  sticky illegal-instruction flag
- issue_count  out  CNT_W  accepted instructions, saturating
- stall_count  out  CNT_W  hazard-stall cycles, saturating

Behaviour:
- Encoding of in_instr:
  - [31:29] op, [28] form, [27:26] vec, [25:24] write
  - [23:20] Y1, [19:16] Y2
  - [15:12] A, [11:8] B, [7:4] C, [3:0] D
- Reset (async, immediate):
  - out_valid=0; all decoded outputs 0 except zero_reg=ZERO_REG.
  - sb_pending=0, err=0, counters=0.
  - A held instruction is discarded; no partial state survives reset.
- Effective pending: eff = sb_pending & ~(wb_valid ? wb_mask : 0). Writeback clears bypass into the same-cycle hazard check.
- Hazard: any of A, B, C, D, or an enabled destination (Y1 if write[0], Y2 if write[1]) that is ≠ ZERO_REG and has its eff bit set.
- slot_free = !out_valid || out_ready.
- in_ready = slot_free && !hazard(in_instr). in_ready is combinational on in_instr, sb_pending, wb_*, out_*.
- Accept = in_valid && in_ready, registered next edge:
  - Decoded fields load; out_valid=1 → latency 1 cycle.
  - Pending bits are set for enabled destinations ≠ ZERO_REG.
  - issue_count increments, saturating at all-ones.
- Illegal instruction: write==2'b11 && Y1==Y2.
  - Accepted (consumed) but not issued: out_valid does not assert for it, no scoreboard set.
  - err sets and stays 1 until reset; issue_count unchanged.
  - It still consumes the slot only if slot_free.
- Output handshake: if out_valid && out_ready && !accept, out_valid falls next edge. Fields are stable while out_valid && !out_ready.
- Scoreboard update per edge: next = (sb_pending & ~clr) | set. Set wins over a same-cycle clear of the same bit.
- wb_mask bits for non-pending registers are ignored. The ZERO_REG bit is always 0.
- stall_count increments each cycle with in_valid && slot_free && hazard (saturating). Backpressure stalls (slot not free) are not counted.
- No combinational path from in_instr to the decoded outputs.

Test Plan:
- Reset, then in_valid with in_instr=0x55501234 → next cycle out_valid=1, op=3'b010, form=1, vec=2'b01, write=2'b01, Y1=5, A=1, B=2, C=3, D=4; sb_pending=0x0020; issue_count=1.
- RAW: after the above, offer 0x55605234 (A=5) with no writeback → in_ready=0, stall_count increments each cycle. Pulse wb_valid with wb_mask=0x0020 → accepted same cycle, sb_pending=0x0040 next.
- Backpressure: out_ready=0 with out_valid=1 → in_ready=0, fields stable for 5 cycles, stall_count unchanged. Raise out_ready with a back-to-back non-hazard instruction → one instruction per cycle, no bubble.
- Illegal: in_instr with write=2'b11, Y1=Y2=7 → accepted, out_valid stays 0, err=1 sticky, sb_pending unchanged.
- Zero-reg and set/clear collision: instruction with Y1=ZERO_REG, write=01 → no pending bit set. Instruction writing r3 accepted in the same cycle as wb_mask=0x0008 → bit 3 remains set.
- Async reset asserted mid-stall with out_valid=1, sb_pending=0x00F0 → out_valid=0, sb_pending=0, counters=0 without waiting for a clock edge.
